// File: rtl/pipe_ctrl_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_hazard_unit
//
// Pipelined RV32I control unit. Decodes the instruction held in the IF/ID
// register and registers a control bundle into EX. The EX destination/write
// enable is then carried into MEM and WB. Also detects load-use hazards,
// squashes ID after a redirect, and produces EX operand forwarding selects.
//
// Optional feature: define PIPE_CTRL_ILLEGAL_TRAP_EN to add the illegal_o
// port, which pulses for one cycle alongside the bubble an unknown opcode
// turns into.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   inst_id          instruction in ID
//   valid_id         inst_id is valid
//   redirect_ex      taken branch/jump resolved in EX this cycle
//   stall_if         hold PC and IF/ID
//   flush_id         invalidate IF/ID
//   ex_*             EX control bundle, destination and valid flag
//   mem_reg_we/rd    MEM write enable/destination
//   wb_reg_we/rd     WB write enable/destination
//   fwd_a, fwd_b     EX operand source: 00 regfile, 10 MEM, 01 WB
//   illegal_o        illegal-opcode pulse (PIPE_CTRL_ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module pipe_ctrl_hazard_unit #(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_id,
  input  logic              valid_id,
  input  logic              redirect_ex,
  output logic              stall_if,
  output logic              flush_id,
  output logic              ex_valid,
  output logic              ex_reg_we,
  output logic              ex_mem_we,
  output logic              ex_alu_imm,
  output logic              ex_lw,
  output logic              ex_jump,
  output logic              ex_jalr,
  output logic              ex_blt,
  output logic              ex_bge,
  output logic              ex_lui,
  output logic              ex_auipc,
  output logic              ex_shamt,
  output logic [2:0]        ex_alu_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_reg_we,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_reg_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_o
`endif
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} stateE;

  typedef struct packed {
    logic       regWe;
    logic       memWe;
    logic       aluImm;
    logic       lw;
    logic       jump;
    logic       jalr;
    logic       blt;
    logic       bge;
    logic       lui;
    logic       auipc;
    logic       shamt;
    logic [2:0] aluCtrl;
  } ctrlT;

  stateE             state_q;
  logic [2:0]        cnt_q;
  logic              exValid_q, exValid_d;
  ctrlT              exCtrl_q, exCtrl_d, decCtrl;
  logic [REG_AW-1:0] exRd_q, exRd_d, exRs1_q, exRs1_d, exRs2_q, exRs2_d;
  logic              memRegWe_q, wbRegWe_q;
  logic [REG_AW-1:0] memRd_q, wbRd_q;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rdId, rs1Id, rs2Id;
  logic              known, usesRs1, usesRs2;
  logic              hazard, stallCond, flushCond, bubble;
  logic              unusedFunct7;

  assign opcode       = inst_id[6:0];
  assign funct3       = inst_id[14:12];
  assign rdId         = inst_id[7 +: REG_AW];
  assign rs1Id        = inst_id[15 +: REG_AW];
  assign rs2Id        = inst_id[20 +: REG_AW];
  assign unusedFunct7 = ^inst_id[31:25];

  // Opcode decode; unknown opcodes clear 'known' and become bubbles.
  always_comb begin
    decCtrl = '0;
    known   = 1'b1;
    usesRs1 = 1'b1;
    usesRs2 = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decCtrl.regWe   = 1'b1;
        decCtrl.aluCtrl = funct3;
        usesRs2         = 1'b1;
      end
      OP_IALU: begin
        decCtrl.regWe   = 1'b1;
        decCtrl.aluImm  = 1'b1;
        decCtrl.aluCtrl = funct3;
        decCtrl.shamt   = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      OP_LOAD: begin
        decCtrl.regWe  = 1'b1;
        decCtrl.aluImm = 1'b1;
        decCtrl.lw     = 1'b1;
      end
      OP_STORE: begin
        decCtrl.memWe  = 1'b1;
        decCtrl.aluImm = 1'b1;
        usesRs2        = 1'b1;
      end
      OP_BRANCH: begin
        decCtrl.aluCtrl = 3'b100;
        decCtrl.blt     = ~funct3[0];
        decCtrl.bge     = funct3[0];
        usesRs2         = 1'b1;
      end
      OP_JAL: begin
        decCtrl.jump  = 1'b1;
        decCtrl.regWe = 1'b1;
        usesRs1       = 1'b0;
      end
      OP_JALR: begin
        decCtrl.jalr   = 1'b1;
        decCtrl.regWe  = 1'b1;
        decCtrl.aluImm = 1'b1;
      end
      OP_LUI: begin
        decCtrl.lui   = 1'b1;
        decCtrl.regWe = 1'b1;
        usesRs1       = 1'b0;
      end
      OP_AUIPC: begin
        decCtrl.auipc = 1'b1;
        decCtrl.regWe = 1'b1;
        usesRs1       = 1'b0;
      end
      default: known = 1'b0;
    endcase
    if (rdId == '0) decCtrl.regWe = 1'b0;
  end

  // Load-use: the load in EX writes a register this ID instruction reads.
  assign hazard = valid_id & exValid_q & exCtrl_q.lw & (exRd_q != '0) &
                  ((usesRs1 & (rs1Id == exRd_q)) | (usesRs2 & (rs2Id == exRd_q)));

  assign stallCond = ((state_q == RUN) & hazard) | (state_q == STALL);
  assign flushCond = redirect_ex | (state_q == FLUSH);
  assign bubble    = stallCond | flushCond | ~valid_id | ~known;

  // A redirect wins over a stall, so the PC is never held while squashing.
  assign stall_if = rst_n & stallCond & ~flushCond;
  assign flush_id = rst_n & flushCond;

  // Next EX contents. Unused source fields are zeroed so that immediate bits
  // sitting in rs positions never raise a forwarding select.
  always_comb begin
    exValid_d = 1'b0;
    exCtrl_d  = '0;
    exRd_d    = '0;
    exRs1_d   = '0;
    exRs2_d   = '0;
    if (!bubble) begin
      exValid_d = 1'b1;
      exCtrl_d  = decCtrl;
      exRd_d    = decCtrl.regWe ? rdId : '0;
      exRs1_d   = usesRs1 ? rs1Id : '0;
      exRs2_d   = usesRs2 ? rs2Id : '0;
    end
  end

  // Control FSM and stage registers. In STALL, cnt holds the number of STALL
  // cycles still to run; in FLUSH it holds the extra FLUSH cycles after this
  // one, so a redirect always costs FLUSH_CYCLES squashed cycles in total and
  // a load-use hazard STALL_CYCLES bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      exValid_q  <= 1'b0;
      exCtrl_q   <= '0;
      exRd_q     <= '0;
      exRs1_q    <= '0;
      exRs2_q    <= '0;
      memRegWe_q <= 1'b0;
      memRd_q    <= '0;
      wbRegWe_q  <= 1'b0;
      wbRd_q     <= '0;
    end else begin
      if (redirect_ex) begin
        if (FLUSH_CYCLES > 1) begin
          state_q <= FLUSH;
          cnt_q   <= 3'(FLUSH_CYCLES - 2);
        end else begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (hazard && (STALL_CYCLES > 1)) begin
              state_q <= STALL;
              cnt_q   <= 3'(STALL_CYCLES - 1);
            end
          end
          STALL: begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_q <= RUN;
          end
          FLUSH: begin
            if (cnt_q == 3'd0) state_q <= RUN;
            else               cnt_q   <= cnt_q - 3'd1;
          end
          default: begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        endcase
      end
      exValid_q  <= exValid_d;
      exCtrl_q   <= exCtrl_d;
      exRd_q     <= exRd_d;
      exRs1_q    <= exRs1_d;
      exRs2_q    <= exRs2_d;
      memRegWe_q <= exCtrl_q.regWe;
      memRd_q    <= exRd_q;
      wbRegWe_q  <= memRegWe_q;
      wbRd_q     <= memRd_q;
    end
  end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Pulse only when the unknown instruction actually leaves ID this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= valid_id & ~known & ~stallCond & ~flushCond;
  end

  assign illegal_o = illegal_q;
`endif

  // MEM result is younger than WB, so it takes priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (memRegWe_q && (memRd_q == exRs1_q) && (exRs1_q != '0))      fwd_a = 2'b10;
    else if (wbRegWe_q && (wbRd_q == exRs1_q) && (exRs1_q != '0))   fwd_a = 2'b01;
    if (memRegWe_q && (memRd_q == exRs2_q) && (exRs2_q != '0))      fwd_b = 2'b10;
    else if (wbRegWe_q && (wbRd_q == exRs2_q) && (exRs2_q != '0))   fwd_b = 2'b01;
  end

  assign ex_valid    = exValid_q;
  assign ex_reg_we   = exCtrl_q.regWe;
  assign ex_mem_we   = exCtrl_q.memWe;
  assign ex_alu_imm  = exCtrl_q.aluImm;
  assign ex_lw       = exCtrl_q.lw;
  assign ex_jump     = exCtrl_q.jump;
  assign ex_jalr     = exCtrl_q.jalr;
  assign ex_blt      = exCtrl_q.blt;
  assign ex_bge      = exCtrl_q.bge;
  assign ex_lui      = exCtrl_q.lui;
  assign ex_auipc    = exCtrl_q.auipc;
  assign ex_shamt    = exCtrl_q.shamt;
  assign ex_alu_ctrl = exCtrl_q.aluCtrl;
  assign ex_rd       = exRd_q;
  assign mem_reg_we  = memRegWe_q;
  assign mem_rd      = memRd_q;
  assign wb_reg_we   = wbRegWe_q;
  assign wb_rd       = wbRd_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_hazard_unit
//
// Scoreboard bench for pipe_ctrl_hazard_unit (STALL_CYCLES=2, FLUSH_CYCLES=2).
// Stimulus drives one ID instruction per cycle and queues the expected
// output values tagged with the cycle in which they must appear; a monitor
// compares queued entries against the DUT outputs at every falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_hazard_unit;

  typedef enum int {
    F_STALL, F_FLUSH, F_EXVALID, F_REGWE, F_MEMWE, F_ALUIMM, F_LW, F_JUMP,
    F_BLT, F_BGE, F_LUI, F_SHAMT, F_ALUCTRL, F_EXRD, F_MEMREGWE, F_MEMRD,
    F_WBWE, F_WBRD, F_FWDA, F_FWDB, F_ILLEGAL
  } fieldE;

  typedef struct {
    int    cyc;
    fieldE f;
    int    val;
    string name;
  } expT;

  localparam logic [31:0] I_ADD3  = 32'h002081B3;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00528333;
  localparam logic [31:0] I_ADDI1 = 32'h00100093;
  localparam logic [31:0] I_ADD2  = 32'h00108133;
  localparam logic [31:0] I_SLLI  = 32'h00309093;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BGE   = 32'h0020D063;
  localparam logic [31:0] I_LUI7  = 32'h000013B7;
  localparam logic [31:0] I_JAL0  = 32'h0000006F;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_id;
  logic        valid_id;
  logic        redirect_ex;
  logic        stall_if, flush_id, ex_valid;
  logic        ex_reg_we, ex_mem_we, ex_alu_imm, ex_lw, ex_jump, ex_jalr;
  logic        ex_blt, ex_bge, ex_lui, ex_auipc, ex_shamt;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_reg_we, wb_reg_we;
  logic [1:0]  fwd_a, fwd_b;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_o;
`endif

  int  cycleNum = 0;
  int  checksTotal = 0;
  int  checksPassed = 0;
  expT sb[$];

  pipe_ctrl_hazard_unit #(
    .REG_AW(5),
    .STALL_CYCLES(2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_id(inst_id),
    .valid_id(valid_id),
    .redirect_ex(redirect_ex),
    .stall_if(stall_if),
    .flush_id(flush_id),
    .ex_valid(ex_valid),
    .ex_reg_we(ex_reg_we),
    .ex_mem_we(ex_mem_we),
    .ex_alu_imm(ex_alu_imm),
    .ex_lw(ex_lw),
    .ex_jump(ex_jump),
    .ex_jalr(ex_jalr),
    .ex_blt(ex_blt),
    .ex_bge(ex_bge),
    .ex_lui(ex_lui),
    .ex_auipc(ex_auipc),
    .ex_shamt(ex_shamt),
    .ex_alu_ctrl(ex_alu_ctrl),
    .ex_rd(ex_rd),
    .mem_reg_we(mem_reg_we),
    .mem_rd(mem_rd),
    .wb_reg_we(wb_reg_we),
    .wb_rd(wb_rd),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b)
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_o(illegal_o)
`endif
  );

  // Free-running clock and cycle counter used to tag expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Reads the current value of one DUT output.
  function automatic int getField(fieldE f);
    case (f)
      F_STALL:    return int'(stall_if);
      F_FLUSH:    return int'(flush_id);
      F_EXVALID:  return int'(ex_valid);
      F_REGWE:    return int'(ex_reg_we);
      F_MEMWE:    return int'(ex_mem_we);
      F_ALUIMM:   return int'(ex_alu_imm);
      F_LW:       return int'(ex_lw);
      F_JUMP:     return int'(ex_jump);
      F_BLT:      return int'(ex_blt);
      F_BGE:      return int'(ex_bge);
      F_LUI:      return int'(ex_lui);
      F_SHAMT:    return int'(ex_shamt);
      F_ALUCTRL:  return int'(ex_alu_ctrl);
      F_EXRD:     return int'(ex_rd);
      F_MEMREGWE: return int'(mem_reg_we);
      F_MEMRD:    return int'(mem_rd);
      F_WBWE:     return int'(wb_reg_we);
      F_WBRD:     return int'(wb_rd);
      F_FWDA:     return int'(fwd_a);
      F_FWDB:     return int'(fwd_b);
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
      F_ILLEGAL:  return int'(illegal_o);
`endif
      default:    return -1;
    endcase
  endfunction

  // Monitor: at each falling edge compare every expectation due this cycle.
  always @(negedge clk) begin
    int idx;
    int got;
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].cyc <= cycleNum) begin
        checksTotal++;
        got = getField(sb[idx].f);
        if (sb[idx].cyc == cycleNum && got == sb[idx].val) begin
          checksPassed++;
        end else begin
          $display("[TB] FAIL %s: got %0d, expected %0d (due cycle %0d, now %0d)",
                   sb[idx].name, got, sb[idx].val, sb[idx].cyc, cycleNum);
        end
        sb.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  // Drive one ID-stage cycle just after the rising edge.
  task automatic applyStimulus(input logic [31:0] inst, input logic valid,
                               input logic redir);
    @(posedge clk);
    #1;
    inst_id     = inst;
    valid_id    = valid;
    redirect_ex = redir;
  endtask

  // Queue an expected output value 'delta' cycles after the current one.
  task automatic checkOutput(input int delta, input fieldE f, input int val,
                             input string name);
    expT e;
    e.cyc  = cycleNum + delta;
    e.f    = f;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, pending %0d", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    inst_id     = '0;
    valid_id    = 1'b0;
    redirect_ex = 1'b0;

    // Reset: everything zero, flush_id held low even with a redirect present.
    applyStimulus(32'h0, 1'b0, 1'b1);
    checkOutput(0, F_FLUSH,   0, "rst_flush");
    checkOutput(0, F_STALL,   0, "rst_stall");
    checkOutput(0, F_EXVALID, 0, "rst_exvalid");
    checkOutput(0, F_WBWE,    0, "rst_wbwe");
    #1;
    checksTotal++;
    if (flush_id === 1'b0) checksPassed++;
    else $display("[TB] FAIL rst_flush_now: got %b, expected 0", flush_id);
    applyStimulus(32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput(0, F_STALL, 0, "postrst_stall");

    // add x3,x1,x2 followed by decode checks on sw, bge, lui, jal x0.
    applyStimulus(I_ADD3, 1'b1, 1'b0);
    checkOutput(0, F_STALL,    0, "add_nostall");
    checkOutput(1, F_EXVALID,  1, "add_exvalid");
    checkOutput(1, F_REGWE,    1, "add_regwe");
    checkOutput(1, F_ALUCTRL,  0, "add_aluctrl");
    checkOutput(1, F_EXRD,     3, "add_exrd");
    checkOutput(1, F_ALUIMM,   0, "add_aluimm");
    checkOutput(1, F_FWDA,     0, "add_fwda");
    checkOutput(2, F_MEMREGWE, 1, "add_memwe");
    checkOutput(3, F_WBWE,     1, "add_wbwe");
    checkOutput(3, F_WBRD,     3, "add_wbrd");
    #1;
    checksTotal++;
    if (stall_if === 1'b0) checksPassed++;
    else $display("[TB] FAIL add_nostall_now: got %b, expected 0", stall_if);
    applyStimulus(I_SW, 1'b1, 1'b0);
    checkOutput(1, F_MEMWE,  1, "sw_memwe");
    checkOutput(1, F_REGWE,  0, "sw_regwe");
    checkOutput(1, F_ALUIMM, 1, "sw_aluimm");
    applyStimulus(I_BGE, 1'b1, 1'b0);
    checkOutput(1, F_ALUCTRL, 4, "bge_aluctrl");
    checkOutput(1, F_BGE,     1, "bge_bge");
    checkOutput(1, F_BLT,     0, "bge_blt");
    applyStimulus(I_LUI7, 1'b1, 1'b0);
    checkOutput(1, F_LUI,   1, "lui_lui");
    checkOutput(1, F_REGWE, 1, "lui_regwe");
    checkOutput(1, F_EXRD,  7, "lui_exrd");
    applyStimulus(I_JAL0, 1'b1, 1'b0);
    checkOutput(1, F_JUMP,  1, "jal_jump");
    checkOutput(1, F_REGWE, 0, "jal_x0_regwe");
    applyStimulus(32'h0, 1'b0, 1'b0);

    // lw x5 then add x6,x5,x5: two bubbles, then add enters with lw retired.
    applyStimulus(I_LW5, 1'b1, 1'b0);
    checkOutput(1, F_LW,     1, "lw_lw");
    checkOutput(1, F_ALUIMM, 1, "lw_aluimm");
    checkOutput(1, F_EXRD,   5, "lw_exrd");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL,   1, "lu_stall0");
    checkOutput(1, F_EXVALID, 0, "lu_bubble0");
    checkOutput(2, F_WBWE,    1, "lw_wbwe");
    checkOutput(2, F_WBRD,    5, "lw_wbrd");
    #1;
    checksTotal++;
    if (stall_if === 1'b1) checksPassed++;
    else $display("[TB] FAIL lu_stall_now: got %b, expected 1", stall_if);
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL,   1, "lu_stall1");
    checkOutput(1, F_EXVALID, 0, "lu_bubble1");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL,   0, "lu_release");
    checkOutput(1, F_EXVALID, 1, "lu_add_exvalid");
    checkOutput(1, F_EXRD,    6, "lu_add_exrd");
    checkOutput(1, F_FWDA,    0, "lu_add_fwda");
    applyStimulus(32'h0, 1'b0, 1'b0);

    // addi x1 ; add x2,x1,x1 (MEM forward) ; slli x1,x1,3 (WB forward).
    applyStimulus(I_ADDI1, 1'b1, 1'b0);
    applyStimulus(I_ADD2, 1'b1, 1'b0);
    checkOutput(0, F_STALL, 0, "b2b_nostall");
    checkOutput(1, F_FWDA,  2, "b2b_fwda_mem");
    checkOutput(1, F_FWDB,  2, "b2b_fwdb_mem");
    applyStimulus(I_SLLI, 1'b1, 1'b0);
    checkOutput(1, F_SHAMT,   1, "slli_shamt");
    checkOutput(1, F_ALUCTRL, 1, "slli_aluctrl");
    checkOutput(1, F_ALUIMM,  1, "slli_aluimm");
    checkOutput(1, F_FWDA,    1, "slli_fwda_wb");
    checkOutput(1, F_FWDB,    0, "slli_fwdb");
    applyStimulus(32'h0, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0);

    // Redirect while in STALL: two flushed cycles, then back to RUN.
    applyStimulus(I_LW5, 1'b1, 1'b0);
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL, 1, "rd_pre_stall");
    applyStimulus(I_ADD6, 1'b1, 1'b1);
    checkOutput(0, F_STALL,   0, "rd_stall0");
    checkOutput(0, F_FLUSH,   1, "rd_flush0");
    checkOutput(1, F_EXVALID, 0, "rd_bubble0");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL,   0, "rd_stall1");
    checkOutput(0, F_FLUSH,   1, "rd_flush1");
    checkOutput(1, F_EXVALID, 0, "rd_bubble1");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_FLUSH,   0, "rd_run_flush");
    checkOutput(0, F_STALL,   0, "rd_run_stall");
    checkOutput(1, F_EXVALID, 1, "rd_run_exvalid");
    applyStimulus(32'h0, 1'b0, 1'b0);

    // Reset asserted mid-STALL clears outputs at once; RUN afterwards.
    applyStimulus(I_LW5, 1'b1, 1'b0);
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    checkOutput(0, F_STALL, 1, "mr_pre_stall");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    rst_n = 1'b0;
    checkOutput(0, F_STALL,    0, "mr_stall");
    checkOutput(0, F_MEMREGWE, 0, "mr_memwe");
    checkOutput(0, F_MEMRD,    0, "mr_memrd");
    checkOutput(0, F_EXVALID,  0, "mr_exvalid");
    applyStimulus(I_ADD6, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkOutput(0, F_STALL,   0, "mr_run_stall");
    checkOutput(1, F_EXVALID, 1, "mr_run_exvalid");
    checkOutput(1, F_EXRD,    6, "mr_run_exrd");
    applyStimulus(32'h0, 1'b0, 1'b0);

    // Unknown opcode becomes a bubble; a flushed one raises no illegal pulse.
    applyStimulus(I_BAD, 1'b1, 1'b0);
    checkOutput(1, F_EXVALID, 0, "bad_exvalid");
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    checkOutput(1, F_ILLEGAL, 1, "bad_illegal_on");
    checkOutput(2, F_ILLEGAL, 0, "bad_illegal_off");
`endif
    applyStimulus(32'h0, 1'b0, 1'b0);
    applyStimulus(I_BAD, 1'b1, 1'b1);
    checkOutput(0, F_FLUSH,   1, "badfl_flush");
    checkOutput(1, F_EXVALID, 0, "badfl_exvalid");
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    checkOutput(1, F_ILLEGAL, 0, "badfl_illegal");
`endif

    repeat (5) applyStimulus(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checksTotal++;
      $display("[TB] FAIL %s: got no sample, expected %0d (due cycle %0d)",
               sb[0].name, sb[0].val, sb[0].cyc);
      sb.delete(0);
    end
    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_hazard_unit.md
Name: pipe_ctrl_hazard_unit

Overview:
- Pipelined successor to the single-cycle RV32I decoder.
- Decodes the instruction in ID and registers a control bundle into EX, MEM and WB.
- Tracks destination registers for load-use stalls and EX-stage forwarding selects.
- Squashes younger instructions on a redirect.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
REG_AW, 5, register-index width (rd/rs1/rs2 fields)
STALL_CYCLES, 1, bubble cycles inserted on a load-use hazard (1..7)
FLUSH_CYCLES, 1, cycles ID is squashed after a redirect, including the redirect cycle (1..7)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_id  in  32  instruction in ID
valid_id  in  1  inst_id is valid
redirect_ex  in  1  taken branch/jump resolved in EX this cycle
stall_if  out  1  hold PC and IF/ID
flush_id  out  1  invalidate IF/ID
ex_valid  out  1  EX holds a real instruction
ex_reg_we, ex_mem_we, ex_alu_imm, ex_lw, ex_jump, ex_jalr, ex_blt, ex_bge, ex_lui, ex_auipc, ex_shamt  out  1 each  EX control bundle
ex_alu_ctrl  out  3  ALU operation
ex_rd  out  REG_AW  EX destination
mem_reg_we  out  1  MEM write enable
mem_rd  out  REG_AW  MEM destination
wb_reg_we  out  1  WB write enable
wb_rd  out  REG_AW  WB destination
fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 10 MEM, 01 WB
illegal_o  out  1  illegal-opcode pulse (present only with ILLEGAL_TRAP_EN)

Behaviour:
- Reset (async, rst_n=0):
  - All stage registers, outputs and counters go to 0; FSM enters RUN.
  - Outputs are 0 while rst_n=0.
- Decode by opcode inst_id[6:0], all active-high:
  - 0110011 R-type: reg_we, alu_ctrl=funct3.
  - 0010011 I-ALU: reg_we, alu_imm, alu_ctrl=funct3, shamt=1 iff funct3 is 001 or 101.
  - 0000011 LW: reg_we, alu_imm, lw, alu_ctrl=000.
  - 0100011 SW: mem_we, alu_imm, alu_ctrl=000.
  - 1100011 branch: alu_ctrl=100; blt if funct3[0]=0, else bge.
  - 1101111 JAL: jump, reg_we.
  - 1100111 JALR: jalr, reg_we, alu_imm.
  - 0110111 LUI: lui, reg_we.
  - 0010111 AUIPC: auipc, reg_we.
  - Any other opcode: bubble.
- reg_we is forced to 0 when rd=0.
- Source use:
  - rs1 is used by all opcodes except JAL, LUI and AUIPC.
  - rs2 is used by R-type, SW and branch.
- Stage latency:
  - ID→EX bundle appears on the next clk edge.
  - mem_* is EX delayed by 1 cycle; wb_* is EX delayed by 2 cycles.
  - A bubble is all-zero controls with ex_valid=0.
- FSM states RUN, STALL, FLUSH; a 3-bit counter cnt is shared.
  - RUN → STALL on load-use hazard: valid_id & ex_valid & ex_lw & ex_rd≠0 & ex_rd equals a used rs.
    - stall_if=1 and a bubble enters EX.
    - cnt=STALL_CYCLES-1.
  - STALL: stall_if=1 and a bubble enters EX each cycle.
    - cnt decrements; return to RUN when cnt=0.
    - The hazard is re-evaluated in RUN.
  - redirect_ex in any state has priority:
    - flush_id=1, a bubble enters EX, stall_if=0.
    - If FLUSH_CYCLES>1: enter FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - FLUSH: flush_id=1 and a bubble enters EX.
    - cnt decrements; return to RUN when cnt=0.
    - A redirect in FLUSH restarts the count.
- stall_if and flush_id are combinational from state and current inputs.
- Forwarding is computed for the instruction in EX using its registered rs1/rs2:
  - MEM match (mem_reg_we & mem_rd=rs & rs≠0) selects 10.
  - Otherwise a WB match selects 01.
  - Otherwise 00.
  - MEM has priority over WB.
- Mid-operation reset aborts STALL/FLUSH immediately.

Optional Feature:
- PIPE_CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode with valid_id=1 produces illegal_o=1 for one cycle, aligned with the bubble in EX.
  - The pulse is suppressed if that cycle is flushed.
- Undefined:
  - The illegal_o port is absent.
  - Unknown opcodes silently become bubbles.

Test Plan:
- Assert rst_n=0 mid-STALL → all outputs 0 immediately; after release, state RUN and stall_if=0.
- inst_id=0x002081B3 (add x3,x1,x2), valid_id=1 → next cycle ex_reg_we=1, ex_alu_ctrl=000, ex_rd=3, ex_alu_imm=0; two cycles later wb_reg_we=1, wb_rd=3.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333):
  - cycle 1: stall_if=1 and a bubble (ex_valid=0) enters EX.
  - cycle 3: add is in EX with fwd_a=fwd_b=01.
- addi x1,x0,1 then add x2,x1,x1 back-to-back → with add in EX, fwd_a=fwd_b=10 and no stall; slli x1,x1,3 (0x00309093) → ex_shamt=1, ex_alu_ctrl=001.
- With FLUSH_CYCLES=2, assert redirect_ex during STALL → stall_if=0 and flush_id=1 for 2 cycles, ex_valid=0 for 2 cycles, then RUN.
- inst_id=0xFFFFFFFF, valid_id=1 → ex_valid=0; with the macro defined illegal_o=1 for exactly 1 cycle, without it no illegal_o port exists.
